// File: rtl/nx_ctrl_arbiter.sv
// Round-robin arbiter for the nexus control inbound stream.
// Holds the grant for a whole packet and routes responses in issue order.
package nx_ctrl_pkg;
  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } control_request_t;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } control_response_t;
endpackage

module nx_ctrl_arbiter
  import nx_ctrl_pkg::*;
#(
  parameter int REQUESTERS  = 2,
  parameter int OUTSTANDING = 8,
  localparam int GW = $clog2(REQUESTERS),
  localparam int CW = $clog2(OUTSTANDING + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  control_request_t [REQUESTERS-1:0]   i_req_data,
  input  logic [REQUESTERS-1:0]               i_req_last,
  input  logic [REQUESTERS-1:0]               i_req_resp,
  input  logic [REQUESTERS-1:0]               i_req_valid,
  output logic [REQUESTERS-1:0]               o_req_ready,
  output control_request_t                    o_ctrl_data,
  output logic                                o_ctrl_valid,
  input  logic                                i_ctrl_ready,
  input  control_response_t                   i_ctrl_resp_data,
  input  logic                                i_ctrl_resp_valid,
  output logic                                o_ctrl_resp_ready,
  output control_response_t                   o_resp_data,
  output logic [REQUESTERS-1:0]               o_resp_valid,
  input  logic [REQUESTERS-1:0]               i_resp_ready,
  output logic [CW-1:0]                       o_outstanding,
  output logic                                o_idle,
  output logic                                o_err_unexpected
);

  localparam int AW = $clog2(OUTSTANDING);
  localparam logic [GW:0] NREQ = (GW+1)'(REQUESTERS);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] mem_q [OUTSTANDING];
  logic [AW:0]   wptr_q, rptr_q;
  logic          err_q;

  logic          empty, full, stall;
  logic          push, pop, xfer, drop;
  logic [GW-1:0] head, pick;
  logic [GW:0]   idx;
  logic          found;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];
  assign stall = i_req_resp[g_q] && full;

  // first valid requester at or after rr_q, wrapping
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = {1'b0, rr_q} + (GW+1)'(i);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && i_req_valid[idx[GW-1:0]]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    rr_d         = rr_q;
    o_req_ready  = '0;
    o_ctrl_valid = 1'b0;
    o_ctrl_data  = i_req_data[g_q];
    xfer         = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          g_d     = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        o_ctrl_valid     = i_req_valid[g_q] && !stall;
        o_req_ready[g_q] = i_ctrl_ready && !stall;
        xfer             = o_ctrl_valid && i_ctrl_ready;
        push             = xfer && i_req_resp[g_q];
        if (xfer && i_req_last[g_q]) begin
          rr_d    = (g_q == GW'(REQUESTERS - 1)) ? '0 : g_q + GW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // with no route entry the response is sunk and flagged
  always_comb begin
    o_resp_data       = i_ctrl_resp_data;
    o_resp_valid      = '0;
    o_ctrl_resp_ready = 1'b1;
    pop               = 1'b0;
    if (!empty) begin
      o_resp_valid[head] = i_ctrl_resp_valid;
      o_ctrl_resp_ready  = i_resp_ready[head];
      pop                = i_ctrl_resp_valid && i_resp_ready[head];
    end
  end

  assign drop = empty && i_ctrl_resp_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      err_q   <= drop;
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < OUTSTANDING; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= g_q;
    end
  end

  assign o_outstanding    = CW'(wptr_q - rptr_q);
  assign o_idle           = (state_q == IDLE) && empty;
  assign o_err_unexpected = err_q;

endmodule

// File: tb/tb_nx_ctrl_arbiter.sv
// Directed bench for nx_ctrl_arbiter: vector table plus
// hand-written sequences for fairness, locking, stall and reset.
module tb_nx_ctrl_arbiter;
  import nx_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  control_request_t [1:0] req_data;
  logic [1:0] req_last, req_resp, req_valid, req_ready;
  control_request_t ctrl_data;
  logic ctrl_valid, ctrl_ready;
  control_response_t cresp_data, resp_data;
  logic cresp_valid, cresp_ready;
  logic [1:0] resp_valid, resp_ready;
  logic [1:0] outst;
  logic idle, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nx_ctrl_arbiter #(.REQUESTERS(2), .OUTSTANDING(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_data(req_data), .i_req_last(req_last),
    .i_req_resp(req_resp), .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .o_ctrl_data(ctrl_data), .o_ctrl_valid(ctrl_valid),
    .i_ctrl_ready(ctrl_ready),
    .i_ctrl_resp_data(cresp_data), .i_ctrl_resp_valid(cresp_valid),
    .o_ctrl_resp_ready(cresp_ready),
    .o_resp_data(resp_data), .o_resp_valid(resp_valid),
    .i_resp_ready(resp_ready),
    .o_outstanding(outst), .o_idle(idle),
    .o_err_unexpected(err)
  );

  typedef struct {
    logic [1:0] v, last, resp;
    logic       cr, rsv;
    logic [1:0] rsr;
    logic [1:0] rdy;
    logic       cv, src;
    logic [1:0] out, rvo;
    logic       crr, idl, er;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l,
                       input logic [1:0] r, input logic rv,
                       input logic [1:0] rr);
    req_valid   = v;
    req_last    = l;
    req_resp    = r;
    ctrl_ready  = 1'b1;
    cresp_valid = rv;
    resp_ready  = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rdy"}, 32'(req_ready), 0);
    chk({nm, "_cv"}, 32'(ctrl_valid), 0);
    chk({nm, "_rvo"}, 32'(resp_valid), 0);
    chk({nm, "_crr"}, 32'(cresp_ready), 1);
    chk({nm, "_out"}, 32'(outst), 0);
    chk({nm, "_idle"}, 32'(idle), 1);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n, exp_g, c0, c1, gg, beats;
  logic prev;
  logic [5:0] pat;

  initial begin
    req_data[0] = '{wr: 1'b1, addr: 8'h10, data: 16'hA0A0};
    req_data[1] = '{wr: 1'b0, addr: 8'h21, data: 16'hB1B1};
    cresp_data  = '{err: 1'b0, data: 16'h5A3C};
    drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b11);

    //         v     last  resp  cr rsv rsr  | rdy  cv src out  rvo  crr idl er
    tv[0]  = '{2'b01,2'b00,2'b00,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};
    tv[1]  = '{2'b01,2'b00,2'b00,1,0,2'b11, 2'b01,1,0,2'd0,2'b00,1,0,0};
    tv[2]  = '{2'b01,2'b00,2'b00,1,0,2'b11, 2'b01,1,0,2'd0,2'b00,1,0,0};
    tv[3]  = '{2'b01,2'b01,2'b01,1,0,2'b11, 2'b01,1,0,2'd0,2'b00,1,0,0};
    tv[4]  = '{2'b00,2'b00,2'b00,1,1,2'b11, 2'b00,0,0,2'd1,2'b01,1,0,0};
    tv[5]  = '{2'b00,2'b00,2'b00,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};
    tv[6]  = '{2'b00,2'b00,2'b00,1,1,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};
    tv[7]  = '{2'b00,2'b00,2'b00,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,1};
    tv[8]  = '{2'b00,2'b00,2'b00,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};
    tv[9]  = '{2'b11,2'b11,2'b00,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};
    tv[10] = '{2'b11,2'b11,2'b00,1,0,2'b11, 2'b10,1,1,2'd0,2'b00,1,0,0};
    tv[11] = '{2'b11,2'b11,2'b00,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};
    tv[12] = '{2'b11,2'b11,2'b00,1,0,2'b11, 2'b01,1,0,2'd0,2'b00,1,0,0};
    tv[13] = '{2'b01,2'b01,2'b01,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};
    tv[14] = '{2'b01,2'b01,2'b01,0,0,2'b11, 2'b00,1,0,2'd0,2'b00,1,0,0};
    tv[15] = '{2'b01,2'b01,2'b01,1,0,2'b11, 2'b01,1,0,2'd0,2'b00,1,0,0};
    tv[16] = '{2'b00,2'b00,2'b00,1,1,2'b10, 2'b00,0,0,2'd1,2'b01,0,0,0};
    tv[17] = '{2'b00,2'b00,2'b00,1,1,2'b01, 2'b00,0,0,2'd1,2'b01,1,0,0};
    tv[18] = '{2'b00,2'b00,2'b00,1,0,2'b11, 2'b00,0,0,2'd0,2'b00,1,1,0};

    // reset values
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      req_valid   = tv[i].v;
      req_last    = tv[i].last;
      req_resp    = tv[i].resp;
      ctrl_ready  = tv[i].cr;
      cresp_valid = tv[i].rsv;
      resp_ready  = tv[i].rsr;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 32'(req_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_cv", i), 32'(ctrl_valid), 32'(tv[i].cv));
      chk($sformatf("v%0d_out", i), 32'(outst), 32'(tv[i].out));
      chk($sformatf("v%0d_rvo", i), 32'(resp_valid), 32'(tv[i].rvo));
      chk($sformatf("v%0d_crr", i), 32'(cresp_ready), 32'(tv[i].crr));
      chk($sformatf("v%0d_idle", i), 32'(idle), 32'(tv[i].idl));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].er));
      if (tv[i].cv)
        chk($sformatf("v%0d_data", i), 32'(ctrl_data),
            32'(req_data[tv[i].src]));
      tick();
    end

    // fairness: both requesters stream single-beat packets
    drive(2'b11, 2'b11, 2'b00, 1'b0, 2'b11);
    n = 0; exp_g = 1; c0 = 0; c1 = 0; prev = 1'b0;
    for (int cyc = 0; cyc < 400 && n < 100; cyc++) begin
      @(negedge clk);
      if (ctrl_valid) begin
        gg = req_ready[1] ? 1 : 0;
        chk("rr_grant", 32'(gg), 32'(exp_g));
        chk("rr_gap", 32'(prev), 0);
        exp_g ^= 1;
        if (gg == 1) c1++; else c0++;
        n++;
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
      tick();
    end
    chk("rr_count", 32'(n), 100);
    chk("rr_req0", 32'(c0), 50);
    chk("rr_req1", 32'(c1), 50);
    drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b11);
    tick();

    // requester 1 locks a 4-beat packet with gaps
    drive(2'b10, 2'b00, 2'b00, 1'b0, 2'b11);
    @(negedge clk);
    chk("lk_idle_rdy", 32'(req_ready), 0);
    tick();
    pat = 6'b110101;
    beats = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = {pat[k], 1'b1};
      req_last  = {(pat[k] && beats == 3), 1'b1};
      @(negedge clk);
      chk("lk_rdy", 32'(req_ready), 32'(2'b10));
      chk("lk_cv", 32'(ctrl_valid), 32'(pat[k]));
      if (ctrl_valid)
        chk("lk_data", 32'(ctrl_data), 32'(req_data[1]));
      tick();
      if (pat[k]) beats++;
    end
    req_valid = 2'b01;
    req_last  = 2'b11;
    @(negedge clk);
    chk("lk_gap_rdy", 32'(req_ready), 0);
    chk("lk_gap_cv", 32'(ctrl_valid), 0);
    tick();
    @(negedge clk);
    chk("lk_next_rdy", 32'(req_ready), 32'(2'b01));
    tick();
    drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b11);
    tick();

    // route FIFO full stall with depth 2, in-order routing
    drive(2'b01, 2'b11, 2'b11, 1'b0, 2'b11);
    @(negedge clk);
    chk("st_out0", 32'(outst), 0);
    tick();
    @(negedge clk);
    chk("st_b1_cv", 32'(ctrl_valid), 1);
    tick();
    drive(2'b10, 2'b11, 2'b11, 1'b0, 2'b11);
    @(negedge clk);
    chk("st_out1", 32'(outst), 1);
    tick();
    @(negedge clk);
    chk("st_b2_rdy", 32'(req_ready), 32'(2'b10));
    tick();
    drive(2'b01, 2'b11, 2'b11, 1'b0, 2'b11);
    @(negedge clk);
    chk("st_out2", 32'(outst), 2);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("st_stall_cv", 32'(ctrl_valid), 0);
      chk("st_stall_rdy", 32'(req_ready), 0);
      chk("st_stall_out", 32'(outst), 2);
      tick();
    end
    drive(2'b01, 2'b11, 2'b11, 1'b1, 2'b11);
    @(negedge clk);
    chk("st_rel_rvo", 32'(resp_valid), 32'(2'b01));
    chk("st_rel_cv", 32'(ctrl_valid), 0);
    chk("st_rel_crr", 32'(cresp_ready), 1);
    chk("st_rel_data", 32'(resp_data), 32'(cresp_data));
    tick();
    drive(2'b01, 2'b11, 2'b11, 1'b0, 2'b11);
    @(negedge clk);
    chk("st_pass_cv", 32'(ctrl_valid), 1);
    chk("st_pass_rdy", 32'(req_ready), 32'(2'b01));
    chk("st_pass_out", 32'(outst), 1);
    tick();
    drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b11);
    @(negedge clk);
    chk("st_ord1_rvo", 32'(resp_valid), 32'(2'b10));
    chk("st_ord1_out", 32'(outst), 2);
    tick();
    @(negedge clk);
    chk("st_ord2_rvo", 32'(resp_valid), 32'(2'b01));
    chk("st_ord2_out", 32'(outst), 1);
    tick();
    drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b11);
    @(negedge clk);
    chk("st_end_out", 32'(outst), 0);
    chk("st_end_idle", 32'(idle), 1);
    tick();

    // reset mid-packet with two outstanding
    drive(2'b01, 2'b00, 2'b11, 1'b0, 2'b11);
    tick();
    @(negedge clk);
    chk("mr_b1_cv", 32'(ctrl_valid), 1);
    tick();
    @(negedge clk);
    chk("mr_b2_out", 32'(outst), 1);
    tick();
    chk("mr_pre_out", 32'(outst), 2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mr");
    drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(2'b00, 2'b00, 2'b00, 1'b1, 2'b11);
    @(negedge clk);
    chk("mr_r1_crr", 32'(cresp_ready), 1);
    chk("mr_r1_rvo", 32'(resp_valid), 0);
    tick();
    cresp_valid = 1'b0;
    @(negedge clk);
    chk("mr_err1", 32'(err), 1);
    tick();
    cresp_valid = 1'b1;
    @(negedge clk);
    chk("mr_r2_err", 32'(err), 0);
    chk("mr_r2_rvo", 32'(resp_valid), 0);
    tick();
    cresp_valid = 1'b0;
    @(negedge clk);
    chk("mr_err2", 32'(err), 1);
    tick();
    @(negedge clk);
    chk("mr_err_clr", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
